// File: rtl/sdram_port_pkg.sv
// Shared types and constants for the 16-bit toggle req/ack SDRAM port.
package sdram_port_pkg;

  localparam int PORT_AW = 22;
  localparam int PORT_DW = 16;

  localparam int                 RD_TIMEOUT_DEF = 64;
  localparam logic [PORT_DW-1:0] ERR_DATA_DEF   = 16'hFFFF;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    RDWAIT = 2'd2
  } port_state_e;

endpackage

// File: rtl/sdram_toggle_port.sv
// Responder side of the toggle req/ack port: latches a pending request, issues it to
// the SDRAM core over valid/ready, and completes it by toggling port_req_ack.
module sdram_toggle_port
  import sdram_port_pkg::*;
#(
  parameter int                 RD_TIMEOUT = RD_TIMEOUT_DEF,
  parameter logic [PORT_DW-1:0] ERR_DATA   = ERR_DATA_DEF
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic [PORT_AW-1:0] port_addr,
  input  logic               port_req,
  input  logic [1:0]         port_ds,
  input  logic [PORT_DW-1:0] port_din,
  input  logic               port_we,
  output logic               port_req_ack,
  output logic [PORT_DW-1:0] port_dout,
  output logic               cmd_valid,
  input  logic               cmd_ready,
  output logic [PORT_AW-1:0] cmd_addr,
  output logic               cmd_we,
  output logic [1:0]         cmd_ds,
  output logic [PORT_DW-1:0] cmd_din,
  input  logic               rd_valid,
  input  logic [PORT_DW-1:0] rd_data,
  output logic               proto_err,
  output logic               timeout_err
);

  localparam int             CW       = (RD_TIMEOUT > 1) ? $clog2(RD_TIMEOUT) : 1;
  localparam logic [CW-1:0]  CNT_LAST = CW'(RD_TIMEOUT - 1);

  port_state_e        state_r;
  port_state_e        state_s;
  logic [CW-1:0]      cnt_r;
  logic [CW-1:0]      cnt_s;
  logic               req_seen_r;
  logic               req_pend_s;
  logic               busy_s;
  logic               latch_s;
  logic               cmd_valid_s;
  logic               ack_tog_s;
  logic               dout_ld_s;
  logic [PORT_DW-1:0] dout_val_s;
  logic               to_set_s;

  assign req_pend_s = (port_req != port_req_ack);
  assign busy_s     = (state_r != IDLE);

  // State register.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (req_pend_s) begin
          state_s = ISSUE;
        end else begin
          state_s = IDLE;
        end
      end
      ISSUE: begin
        if (cmd_ready) begin
          state_s = cmd_we ? IDLE : RDWAIT;
        end else begin
          state_s = ISSUE;
        end
      end
      RDWAIT: begin
        if (rd_valid || (cnt_r == CNT_LAST)) begin
          state_s = IDLE;
        end else begin
          state_s = RDWAIT;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // Output/datapath controls; real read data beats the timeout on the same cycle.
  always_comb begin
    latch_s     = 1'b0;
    cmd_valid_s = cmd_valid;
    ack_tog_s   = 1'b0;
    dout_ld_s   = 1'b0;
    dout_val_s  = rd_data;
    cnt_s       = cnt_r;
    to_set_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (req_pend_s) begin
          latch_s     = 1'b1;
          cmd_valid_s = 1'b1;
        end else begin
          cmd_valid_s = 1'b0;
        end
      end
      ISSUE: begin
        if (cmd_ready) begin
          cmd_valid_s = 1'b0;
          if (cmd_we) begin
            ack_tog_s = 1'b1;
          end else begin
            cnt_s = {CW{1'b0}};
          end
        end else begin
          cmd_valid_s = 1'b1;
        end
      end
      RDWAIT: begin
        if (rd_valid) begin
          dout_ld_s  = 1'b1;
          dout_val_s = rd_data;
          ack_tog_s  = 1'b1;
        end else if (cnt_r == CNT_LAST) begin
          dout_ld_s  = 1'b1;
          dout_val_s = ERR_DATA;
          ack_tog_s  = 1'b1;
          to_set_s   = 1'b1;
        end else begin
          cnt_s = cnt_r + CW'(1'b1);
        end
      end
      default: begin
        cmd_valid_s = 1'b0;
      end
    endcase
  end

  // Registered outputs, request latch, timeout counter and sticky error flags.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      cmd_valid    <= 1'b0;
      port_dout    <= {PORT_DW{1'b0}};
      proto_err    <= 1'b0;
      timeout_err  <= 1'b0;
      cnt_r        <= {CW{1'b0}};
      port_req_ack <= port_req;
      req_seen_r   <= port_req;
      cmd_addr     <= {PORT_AW{1'b0}};
      cmd_we       <= 1'b0;
      cmd_ds       <= 2'b00;
      cmd_din      <= {PORT_DW{1'b0}};
    end else begin
      cmd_valid   <= cmd_valid_s;
      cnt_r       <= cnt_s;
      timeout_err <= timeout_err | to_set_s;
      proto_err   <= proto_err | (busy_s && (port_req != req_seen_r));
      if (ack_tog_s) begin
        port_req_ack <= ~port_req_ack;
      end
      if (dout_ld_s) begin
        port_dout <= dout_val_s;
      end
      if (latch_s) begin
        req_seen_r <= port_req;
        cmd_addr   <= port_addr;
        cmd_we     <= port_we;
        cmd_ds     <= port_we ? port_ds : 2'b11;
        cmd_din    <= port_din;
      end
    end
  end

endmodule

// File: tb/tb_sdram_toggle_port.sv
// Directed bench for sdram_toggle_port: reset, write, stalled read, back-to-back,
// timeout (including the rd_valid race) and protocol-violation scenarios.
module tb_sdram_toggle_port;
  import sdram_port_pkg::*;

  logic               clk = 1'b0;
  logic               resetn;
  logic [PORT_AW-1:0] port_addr;
  logic               port_req;
  logic [1:0]         port_ds;
  logic [PORT_DW-1:0] port_din;
  logic               port_we;
  logic               port_req_ack;
  logic [PORT_DW-1:0] port_dout;
  logic               cmd_valid;
  logic               cmd_ready;
  logic [PORT_AW-1:0] cmd_addr;
  logic               cmd_we;
  logic [1:0]         cmd_ds;
  logic [PORT_DW-1:0] cmd_din;
  logic               rd_valid;
  logic [PORT_DW-1:0] rd_data;
  logic               proto_err;
  logic               timeout_err;

  int   n_checks = 0;
  int   n_fail   = 0;
  logic exp_ack;

  always #5 clk = ~clk;

  sdram_toggle_port #(.RD_TIMEOUT(8), .ERR_DATA(16'hFFFF)) dut (
    .clk(clk), .resetn(resetn), .port_addr(port_addr), .port_req(port_req),
    .port_ds(port_ds), .port_din(port_din), .port_we(port_we),
    .port_req_ack(port_req_ack), .port_dout(port_dout), .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_we(cmd_we), .cmd_ds(cmd_ds),
    .cmd_din(cmd_din), .rd_valid(rd_valid), .rd_data(rd_data),
    .proto_err(proto_err), .timeout_err(timeout_err)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    resetn = 1'b0; port_req = 1'b1; port_addr = 22'h0; port_ds = 2'b00;
    port_din = 16'h0; port_we = 1'b0; cmd_ready = 1'b0; rd_valid = 1'b0; rd_data = 16'h0;
    step(); step(); step();
    resetn = 1'b1;
    step();
    exp_ack = 1'b1;
    n_checks++; if (port_req_ack !== exp_ack) begin n_fail++; $display("FAIL reset_ack: got %b want %b", port_req_ack, exp_ack); end
    n_checks++; if (port_dout !== 16'h0000) begin n_fail++; $display("FAIL reset_dout: got %h want 0000", port_dout); end
    for (int i = 0; i < 5; i++) begin
      n_checks++; if (cmd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_cmd_valid[%0d]: got %b want 0", i, cmd_valid); end
      step();
    end
    n_checks++; if (proto_err !== 1'b0) begin n_fail++; $display("FAIL reset_proto_err: got %b want 0", proto_err); end
    n_checks++; if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL reset_timeout_err: got %b want 0", timeout_err); end
  endtask

  task automatic test_write();
    port_addr = 22'h12345; port_ds = 2'b01; port_din = 16'hA55A; port_we = 1'b1;
    cmd_ready = 1'b1; port_req = ~port_req;
    step(); // E0
    n_checks++; if (cmd_valid !== 1'b1) begin n_fail++; $display("FAIL wr_cmd_valid: got %b want 1", cmd_valid); end
    n_checks++; if (cmd_addr !== 22'h12345) begin n_fail++; $display("FAIL wr_cmd_addr: got %h want 12345", cmd_addr); end
    n_checks++; if (cmd_we !== 1'b1) begin n_fail++; $display("FAIL wr_cmd_we: got %b want 1", cmd_we); end
    n_checks++; if (cmd_ds !== 2'b01) begin n_fail++; $display("FAIL wr_cmd_ds: got %b want 01", cmd_ds); end
    n_checks++; if (cmd_din !== 16'hA55A) begin n_fail++; $display("FAIL wr_cmd_din: got %h want a55a", cmd_din); end
    n_checks++; if (port_req_ack !== exp_ack) begin n_fail++; $display("FAIL wr_ack_early: got %b want %b", port_req_ack, exp_ack); end
    step(); // E1
    exp_ack = ~exp_ack;
    n_checks++; if (port_req_ack !== exp_ack) begin n_fail++; $display("FAIL wr_ack: got %b want %b", port_req_ack, exp_ack); end
    n_checks++; if (cmd_valid !== 1'b0) begin n_fail++; $display("FAIL wr_cmd_valid_drop: got %b want 0", cmd_valid); end
    n_checks++; if (port_dout !== 16'h0000) begin n_fail++; $display("FAIL wr_dout_kept: got %h want 0000", port_dout); end
    step();
    n_checks++; if (cmd_valid !== 1'b0) begin n_fail++; $display("FAIL wr_no_retrigger: got %b want 0", cmd_valid); end
  endtask

  task automatic test_read_stall();
    port_addr = 22'h00ABC; port_ds = 2'b01; port_we = 1'b0; cmd_ready = 1'b0;
    port_req = ~port_req;
    step(); // E0
    n_checks++; if (cmd_ds !== 2'b11) begin n_fail++; $display("FAIL rd_cmd_ds: got %b want 11", cmd_ds); end
    n_checks++; if (cmd_we !== 1'b0) begin n_fail++; $display("FAIL rd_cmd_we: got %b want 0", cmd_we); end
    for (int i = 0; i < 3; i++) begin
      if (i == 1) begin rd_valid = 1'b1; rd_data = 16'hDEAD; end
      else begin rd_valid = 1'b0; end
      step();
      n_checks++; if (cmd_valid !== 1'b1 || cmd_addr !== 22'h00ABC) begin n_fail++; $display("FAIL rd_stall_hold[%0d]: got v=%b a=%h want v=1 a=00abc", i, cmd_valid, cmd_addr); end
    end
    rd_valid = 1'b0;
    n_checks++; if (port_dout !== 16'h0000) begin n_fail++; $display("FAIL rd_issue_ignores_rdvalid: got %h want 0000", port_dout); end
    cmd_ready = 1'b1;
    step(); // accepted
    n_checks++; if (cmd_valid !== 1'b0) begin n_fail++; $display("FAIL rd_cmd_accept: got %b want 0", cmd_valid); end
    for (int i = 0; i < 3; i++) step();
    n_checks++; if (port_req_ack !== exp_ack || port_dout !== 16'h0000) begin n_fail++; $display("FAIL rd_wait_idle: got ack=%b dout=%h want ack=%b dout=0000", port_req_ack, port_dout, exp_ack); end
    rd_valid = 1'b1; rd_data = 16'hBEEF;
    step();
    rd_valid = 1'b0;
    exp_ack = ~exp_ack;
    n_checks++; if (port_req_ack !== exp_ack) begin n_fail++; $display("FAIL rd_ack: got %b want %b", port_req_ack, exp_ack); end
    n_checks++; if (port_dout !== 16'hBEEF) begin n_fail++; $display("FAIL rd_dout: got %h want beef", port_dout); end
    step();
  endtask

  task automatic test_back_to_back();
    cmd_ready = 1'b1; port_we = 1'b0; port_addr = 22'h10;
    port_req = ~port_req;
    step(); // E0
    n_checks++; if (cmd_valid !== 1'b1 || cmd_addr !== 22'h10) begin n_fail++; $display("FAIL b2b_cmd1: got v=%b a=%h want v=1 a=10", cmd_valid, cmd_addr); end
    step(); // E1
    rd_valid = 1'b1; rd_data = 16'h1111;
    step(); // E2: first ack
    rd_valid = 1'b0;
    exp_ack = ~exp_ack;
    n_checks++; if (port_req_ack !== exp_ack || port_dout !== 16'h1111) begin n_fail++; $display("FAIL b2b_ack1: got ack=%b dout=%h want ack=%b dout=1111", port_req_ack, port_dout, exp_ack); end
    port_addr = 22'h11; port_req = ~port_req;
    step(); // E3
    n_checks++; if (cmd_valid !== 1'b1 || cmd_addr !== 22'h11) begin n_fail++; $display("FAIL b2b_cmd2: got v=%b a=%h want v=1 a=11", cmd_valid, cmd_addr); end
    step(); // E4
    n_checks++; if (port_dout !== 16'h1111 || port_req_ack !== exp_ack) begin n_fail++; $display("FAIL b2b_hold: got ack=%b dout=%h want ack=%b dout=1111", port_req_ack, port_dout, exp_ack); end
    rd_valid = 1'b1; rd_data = 16'h2222;
    step(); // E5
    rd_valid = 1'b0;
    exp_ack = ~exp_ack;
    n_checks++; if (port_req_ack !== exp_ack || port_dout !== 16'h2222) begin n_fail++; $display("FAIL b2b_ack2: got ack=%b dout=%h want ack=%b dout=2222", port_req_ack, port_dout, exp_ack); end
    n_checks++; if (proto_err !== 1'b0) begin n_fail++; $display("FAIL b2b_proto_err: got %b want 0", proto_err); end
    step();
  endtask

  task automatic test_timeout_race();
    cmd_ready = 1'b1; port_we = 1'b0; port_addr = 22'h30;
    port_req = ~port_req;
    step(); // E0
    step(); // E1: into RDWAIT
    for (int i = 0; i < 7; i++) step();
    rd_valid = 1'b1; rd_data = 16'h5A5A;
    step(); // last allowed cycle
    rd_valid = 1'b0;
    exp_ack = ~exp_ack;
    n_checks++; if (port_req_ack !== exp_ack || port_dout !== 16'h5A5A) begin n_fail++; $display("FAIL race_data: got ack=%b dout=%h want ack=%b dout=5a5a", port_req_ack, port_dout, exp_ack); end
    n_checks++; if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL race_timeout_err: got %b want 0", timeout_err); end
    step();
  endtask

  task automatic test_timeout();
    cmd_ready = 1'b1; port_we = 1'b0; port_addr = 22'h3F;
    port_req = ~port_req;
    step(); // E0
    step(); // E1
    for (int i = 0; i < 7; i++) step();
    n_checks++; if (port_req_ack !== exp_ack || timeout_err !== 1'b0) begin n_fail++; $display("FAIL to_early: got ack=%b terr=%b want ack=%b terr=0", port_req_ack, timeout_err, exp_ack); end
    step(); // timeout edge
    exp_ack = ~exp_ack;
    n_checks++; if (port_req_ack !== exp_ack) begin n_fail++; $display("FAIL to_ack: got %b want %b", port_req_ack, exp_ack); end
    n_checks++; if (port_dout !== 16'hFFFF) begin n_fail++; $display("FAIL to_dout: got %h want ffff", port_dout); end
    n_checks++; if (timeout_err !== 1'b1) begin n_fail++; $display("FAIL to_err: got %b want 1", timeout_err); end
    rd_valid = 1'b1; rd_data = 16'h1234;
    step();
    rd_valid = 1'b0;
    n_checks++; if (port_dout !== 16'hFFFF || port_req_ack !== exp_ack) begin n_fail++; $display("FAIL to_late_rdvalid: got ack=%b dout=%h want ack=%b dout=ffff", port_req_ack, port_dout, exp_ack); end
    step();
  endtask

  task automatic test_proto();
    cmd_ready = 1'b1; port_we = 1'b0; port_addr = 22'h20;
    port_req = ~port_req;
    step(); // E0
    step(); // E1: RDWAIT
    port_req = ~port_req;
    step();
    n_checks++; if (proto_err !== 1'b1) begin n_fail++; $display("FAIL proto_err_set: got %b want 1", proto_err); end
    port_req = ~port_req;
    step();
    n_checks++; if (cmd_valid !== 1'b0) begin n_fail++; $display("FAIL proto_no_cmd: got %b want 0", cmd_valid); end
    rd_valid = 1'b1; rd_data = 16'h7777;
    step();
    rd_valid = 1'b0;
    exp_ack = ~exp_ack;
    n_checks++; if (port_req_ack !== exp_ack || port_dout !== 16'h7777) begin n_fail++; $display("FAIL proto_complete: got ack=%b dout=%h want ack=%b dout=7777", port_req_ack, port_dout, exp_ack); end
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++; if (cmd_valid !== 1'b0 || port_req_ack !== exp_ack) begin n_fail++; $display("FAIL proto_no_second[%0d]: got v=%b ack=%b want v=0 ack=%b", i, cmd_valid, port_req_ack, exp_ack); end
    end
    n_checks++; if (proto_err !== 1'b1) begin n_fail++; $display("FAIL proto_err_sticky: got %b want 1", proto_err); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read_stall();
    test_back_to_back();
    test_timeout_race();
    test_timeout();
    test_proto();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sdram_toggle_port.md
Name: sdram_toggle_port

Overview:
- Responder end of the 16-bit toggle req/ack memory port used by the RV-to-SDRAM adapter and other 16-bit port clients.
- A request is pending when port_req differs from port_req_ack.
- The block latches the request and hands it to the SDRAM core command channel with a valid/ready handshake.
- Read data is returned on port_dout, and completion is signalled by toggling port_req_ack.

Parameters:
- RD_TIMEOUT, 64: cycles allowed in RDWAIT before a forced completion. Range 2..1023.
- ERR_DATA, 16'hFFFF: value placed on port_dout when a read times out.

Ports:
- clk  in  1  clock
- resetn  in  1  synchronous active-low reset
- port_addr  in  22  word address [22:1]; valid while a request is pending
- port_req  in  1  toggle request
- port_ds  in  2  byte enables for writes, active high ([1] = upper byte)
- port_din  in  16  write data
- port_we  in  1  1 = write, 0 = read
- port_req_ack  out  1  toggle acknowledge
- port_dout  out  16  read data, held until the next read completes
- cmd_valid  out  1  command to the SDRAM core
- cmd_ready  in  1  core accepts the command this cycle
- cmd_addr  out  22  latched address
- cmd_we  out  1  latched write flag
- cmd_ds  out  2  port_ds for writes; 2'b11 for reads
- cmd_din  out  16  latched write data
- rd_valid  in  1  read data strobe from the core
- rd_data  in  16  read data
- proto_err  out  1  sticky: port_req toggled while busy
- timeout_err  out  1  sticky: read timed out

Behaviour:
- Reset (resetn = 0 at a clk edge):
  - state <= IDLE; cmd_valid <= 0; port_dout <= 0; proto_err <= 0; timeout_err <= 0; timeout counter <= 0.
  - port_req_ack <= port_req. No spurious request is seen after reset.
  - Reset mid-operation abandons the transaction. Any later rd_valid is ignored.
- All outputs are registered. cmd_addr, cmd_we, cmd_ds and cmd_din are stable while cmd_valid = 1.
- State IDLE:
  - If port_req != port_req_ack, latch port_addr, port_we, port_ds, port_din and port_req into req_seen.
  - Set cmd_valid <= 1 and go to ISSUE.
- State ISSUE:
  - cmd_valid is held at 1 until the edge where cmd_ready = 1. At that edge cmd_valid <= 0.
  - For a write: toggle port_req_ack and go to IDLE.
  - For a read: clear the timeout counter and go to RDWAIT.
- State RDWAIT:
  - rd_valid = 1: port_dout <= rd_data, toggle port_req_ack, go to IDLE.
  - Otherwise the counter increments. At counter == RD_TIMEOUT-1 with no rd_valid: port_dout <= ERR_DATA, timeout_err <= 1, toggle port_req_ack, go to IDLE.
  - rd_valid on the timeout cycle wins: real data is returned and timeout_err is not set.
- Latency, with the toggle visible before edge E0:
  - cmd_valid is high after E0.
  - With cmd_ready = 1 at E1, a write acks after E1 (2 cycles).
  - A read acks after the rd_valid edge.
- port_dout changes in the same cycle as the ack toggle, never otherwise. Writes leave port_dout unchanged. This lets the initiator sample data on the cycle it sees req == ack, or any later cycle.
- In the cycle after the ack, IDLE sees port_req == port_req_ack, so there is no retrigger.
  - A new toggle arriving in that same cycle is accepted normally.
  - Minimum spacing between commands is one IDLE cycle.
- While busy (ISSUE or RDWAIT), if port_req != req_seen: proto_err <= 1. The current transaction still completes normally. The second toggle is not queued; req == ack then reads as idle.
- rd_valid in IDLE or ISSUE is ignored.
- Address and data are passed through unmodified; no width arithmetic.

Decomposition:
- Shared package sdram_port_pkg:
  - state encoding IDLE = 0, ISSUE = 1, RDWAIT = 2
  - PORT_AW = 22, PORT_DW = 16
  - default RD_TIMEOUT and ERR_DATA constants
- Single module; no sub-module. The timeout counter is inline, with width $clog2(RD_TIMEOUT).

Test Plan:
- Reset with port_req = 1 held, then release → port_req_ack = 1; cmd_valid stays 0 for 5 cycles; both error flags 0.
- Write: toggle req with addr 22'h12345, ds 2'b01, din 16'hA55A, cmd_ready tied 1 → cmd_valid for 1 cycle with those fields; ack toggles 2 cycles after the req toggle; port_dout unchanged.
- Read: toggle req; cmd_ready low for 3 cycles, then high; rd_valid with 16'hBEEF 4 cycles later → cmd_ds = 2'b11; cmd fields held while stalled; port_dout = 16'hBEEF in the same cycle as the ack toggle.
- Back-to-back, RV 32-bit pattern: read addr 0x10 then 0x11, second toggle issued on the ack cycle, data 16'h1111 then 16'h2222 → two commands in order; port_dout 16'h1111 held until the second ack, then 16'h2222; proto_err = 0.
- Timeout: RD_TIMEOUT = 8, read with no rd_valid → ack toggles with port_dout = 16'hFFFF and timeout_err = 1. A late rd_valid is ignored: port_dout stays 16'hFFFF.
- Protocol violation: toggle req twice while in RDWAIT → proto_err = 1; transaction completes on rd_valid; no second cmd_valid is issued.
